// File: rtl/dmem_ctrl.sv
// Data-memory access controller.
// Turns single-cycle load/store requests from the MEM stage into a
// req/ack handshake with a variable-latency external memory. The pipeline
// is stalled until the access completes or a timeout aborts it.
module dmem_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16   // max BUSY cycles before abort, >= 2
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              err,
  input  logic              err_clr,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ext_req;
  logic              r_ext_we;
  logic [ADDR_W-1:0] r_ext_addr;
  logic [DATA_W-1:0] r_ext_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic w_req;
  logic w_aligned;
  logic w_idle;
  logic w_busy;
  logic w_timeout;
  logic w_err_set;

  assign w_req     = mem_read | mem_write;
  assign w_aligned = (addr[1:0] == 2'b00);
  assign w_idle    = (r_state == S_IDLE);
  assign w_busy    = (r_state == S_BUSY);

  // Abort only when the last allowed BUSY cycle passes without an ack;
  // an ack arriving on that same cycle still completes normally.
  assign w_timeout = w_busy & ~ext_ack & (r_cnt == CNT_LAST);

  // Error sources: misaligned request, conflicting read+write, timeout.
  assign w_err_set = (w_idle & w_req & (~w_aligned | (mem_read & mem_write)))
                   | w_timeout;

  // NOTE: stall is gated by arst so it drops the instant reset asserts,
  // even while the datapath is still presenting a request.
  assign stall = ~arst & ((w_idle & w_req & w_aligned) | w_busy);

  // Access sequencer: accept in IDLE, wait for ack or timeout in BUSY,
  // report completion for one cycle in DONE.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ext_req   <= 1'b0;
      r_ext_we    <= 1'b0;
      r_ext_addr  <= '0;
      r_ext_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, so the order of statements here does not matter.
      case (r_state)
        S_IDLE: begin
          if (w_req && w_aligned) begin
            r_ext_req   <= 1'b1;
            r_ext_we    <= mem_write;   // read+write together performs a write
            r_ext_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_ext_wdata <= wdata;
            r_cnt       <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (ext_ack) begin
            if (!r_ext_we) begin
              r_rdata <= ext_rdata;
            end
            r_ext_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            if (!r_ext_we) begin
              r_rdata <= '0;
            end
            r_ext_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // The datapath still shows the finished instruction; ignore it.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error flag; a new error on the same cycle beats the clear.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign ext_req   = r_ext_req;
  assign ext_we    = r_ext_we;
  assign ext_addr  = r_ext_addr;
  assign ext_wdata = r_ext_wdata;
  assign rdata     = r_rdata;
  assign err       = r_err;

endmodule
